// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and oversampling constants for the UART core
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample prescaler, one-cycle tick every CLK_DIV clocks
// Ports: clk, rst_n (async, active-low), clr_i (sync restart of the count), tick_o (count == CLK_DIV-1)
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (clr_i || tick_o) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with prescaler, 16x RX oversampling, parity and stop-bit options
// Ports: clk, rst_n (async, active-low)
//   TX: tx_data/tx_valid in, tx_ready (idle only), tx_busy, tx_out (idle high)
//   RX: rx_in (async) in, rx_data (held), rx_valid (1-cycle pulse), rx_parity_err, rx_frame_err
module uart_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam logic [3:0] SUB_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SUB_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] DB_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] SB_LAST  = 3'(STOP_BITS - 1);
  localparam logic       P_ODD    = 1'(PARITY_ODD);
  uart_state_e tx_st_q, rx_st_q;
  logic [DATA_BITS-1:0] tx_sh_q, rx_sh_q;
  logic [3:0] tx_sub_q, rx_sub_q;
  logic [2:0] tx_bit_q, rx_bit_q;
  logic [1:0] sync_q;
  logic tx_tick, rx_tick, tx_go, rx_go, tx_par_q, rx_par_q, rx_brk_q, rxs;
  assign tx_go    = tx_valid && tx_st_q == IDLE;
  assign tx_ready = tx_st_q == IDLE;
  assign tx_busy  = !tx_ready;
  assign rxs      = sync_q[1];
  assign rx_go    = rx_st_q == IDLE && !rxs;
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tx_tick (.clk(clk), .rst_n(rst_n), .clr_i(tx_go), .tick_o(tx_tick));
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_rx_tick (.clk(clk), .rst_n(rst_n), .clr_i(rx_go), .tick_o(rx_tick));
  // tx_out is registered so the line changes exactly on bit boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_st_q  <= IDLE;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_sub_q <= '0;
      tx_bit_q <= '0;
      tx_out   <= 1'b1;
    end else if (tx_go) begin
      tx_st_q  <= START;
      tx_sh_q  <= tx_data;
      tx_par_q <= ^tx_data ^ P_ODD;
      tx_sub_q <= '0;
      tx_bit_q <= '0;
      tx_out   <= 1'b0;
    end else if (tx_st_q != IDLE && tx_tick) begin
      tx_sub_q <= tx_sub_q + 4'd1;
      if (tx_sub_q == SUB_LAST)
        case (tx_st_q)
          START: begin
            tx_st_q <= DATA;
            tx_out  <= tx_sh_q[0];
            tx_sh_q <= tx_sh_q >> 1;
          end
          DATA: if (tx_bit_q != DB_LAST) begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_out   <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end else begin
            tx_bit_q <= '0;
            tx_st_q  <= PARITY_EN != 0 ? PARITY : STOP;
            tx_out   <= PARITY_EN != 0 ? tx_par_q : 1'b1;
          end
          PARITY: begin
            tx_st_q <= STOP;
            tx_out  <= 1'b1;
          end
          STOP: if (tx_bit_q == SB_LAST) tx_st_q <= IDLE;
                else tx_bit_q <= tx_bit_q + 3'd1;
          default: tx_st_q <= IDLE;
        endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], rx_in};
  // START waits half a bit, then every later sample lands mid-bit 16 ticks apart;
  // rx_brk_q parks the FSM in STOP until a low stop bit (break) releases the line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_st_q       <= IDLE;
      rx_sh_q       <= '0;
      rx_par_q      <= 1'b0;
      rx_brk_q      <= 1'b0;
      rx_sub_q      <= '0;
      rx_bit_q      <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_go) begin
        rx_st_q  <= START;
        rx_sub_q <= '0;
        rx_bit_q <= '0;
      end else if (rx_brk_q) begin
        if (rxs) begin
          rx_brk_q <= 1'b0;
          rx_st_q  <= IDLE;
        end
      end else if (rx_st_q != IDLE && rx_tick) begin
        rx_sub_q <= rx_sub_q + 4'd1;
        case (rx_st_q)
          START: if (rx_sub_q == SUB_MID) begin
            rx_sub_q <= '0;
            rx_st_q  <= rxs ? IDLE : DATA;
          end
          DATA: if (rx_sub_q == SUB_LAST) begin
            rx_sh_q  <= {rxs, rx_sh_q[DATA_BITS-1:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == DB_LAST) begin
              rx_bit_q <= '0;
              rx_st_q  <= PARITY_EN != 0 ? PARITY : STOP;
            end
          end
          PARITY: if (rx_sub_q == SUB_LAST) begin
            rx_par_q <= rxs;
            rx_st_q  <= STOP;
          end
          STOP: if (rx_sub_q == SUB_LAST) begin
            rx_data       <= rx_sh_q;
            rx_valid      <= 1'b1;
            rx_parity_err <= PARITY_EN != 0 && (rx_par_q != (^rx_sh_q ^ P_ODD));
            rx_frame_err  <= !rxs;
            rx_brk_q      <= !rxs;
            rx_st_q       <= rxs ? IDLE : STOP;
          end
          default: rx_st_q <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: checks three uart_param configurations against a frame-level reference model
module tb_uart_param;
  localparam int N = 3;
  typedef logic bq_t [$];
  function automatic int cd(input int k); return k == 2 ? 2 : 4; endfunction
  function automatic int pe(input int k); return k != 0 ? 1 : 0; endfunction
  function automatic int po(input int k); return k == 2 ? 1 : 0; endfunction
  function automatic int sb(input int k); return k == 2 ? 2 : 1; endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data [N];
  logic [7:0] rx_data [N];
  logic tx_valid [N];
  logic tx_ready [N];
  logic tx_busy [N];
  logic tx_out [N];
  logic rx_in [N];
  logic rx_valid [N];
  logic rx_perr [N];
  logic rx_ferr [N];
  logic lb [N];
  logic rx_drv [N];
  logic [9:0] rxq [N][$];
  logic [9:0] expq [N][$];
  int rd [N];
  int ntests = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    assign rx_in[g] = lb[g] ? tx_out[g] : rx_drv[g];
    uart_param #(.CLK_DIV(cd(g)), .DATA_BITS(8), .PARITY_EN(pe(g)), .PARITY_ODD(po(g)), .STOP_BITS(sb(g))) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .tx_busy(tx_busy[g]), .tx_out(tx_out[g]), .rx_in(rx_in[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .rx_parity_err(rx_perr[g]), .rx_frame_err(rx_ferr[g]));
  end
  always @(negedge clk)
    for (int k = 0; k < N; k++)
      if (rx_valid[k] === 1'b1) rxq[k].push_back({rx_perr[k], rx_ferr[k], rx_data[k]});
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Serial frame as a list of line levels, one per bit period
  function automatic bq_t frame(input int k, input logic [7:0] d, input bit bp, input bit bs);
    bq_t q;
    bit par;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    par = ($countones(d) % 2 == 1) ^ (po(k) == 1);
    if (pe(k) != 0) q.push_back(par ^ bp);
    for (int s = 0; s < sb(k); s++) q.push_back(!(s == 0 && bs));
    return q;
  endfunction
  task automatic tx_frame(input int k, input logic [7:0] d);
    bq_t q;
    int bl, w;
    q = frame(k, d, 1'b0, 1'b0);
    bl = 16 * cd(k);
    w = 0;
    while (!tx_ready[k] && w < 2000) begin step(1); w++; end
    chk($sformatf("tx_ready_idle[%0d]", k), tx_ready[k], 1);
    tx_data[k] = d;
    tx_valid[k] = 1'b1;
    step(1);
    tx_valid[k] = 1'b0;
    tx_data[k] = 8'($urandom);
    chk($sformatf("tx_busy_start[%0d]", k), tx_busy[k], 1);
    for (int i = 0; i < q.size(); i++) begin
      if (i == 2) begin tx_valid[k] = 1'b1; tx_data[k] = ~d; end
      if (i == 3) tx_valid[k] = 1'b0;
      chk($sformatf("tx_bit%0d_first[%0d] d=%0h", i, k, d), tx_out[k], q[i]);
      step(bl - 1);
      chk($sformatf("tx_bit%0d_last[%0d] d=%0h", i, k, d), tx_out[k], q[i]);
      if (i == q.size() - 1) chk($sformatf("tx_ready_end[%0d]", k), tx_ready[k], 0);
      step(1);
    end
    chk($sformatf("tx_ready_after[%0d]", k), tx_ready[k], 1);
    chk($sformatf("tx_busy_after[%0d]", k), tx_busy[k], 0);
    step(1);
    chk($sformatf("tx_no_queue[%0d]", k), {tx_ready[k], tx_out[k]}, 2'b11);
    if (lb[k]) expq[k].push_back({2'b00, d});
  endtask
  task automatic rx_frame(input int k, input logic [7:0] d, input bit bp, input bit bs, input int hold);
    bq_t q;
    int bl;
    q = frame(k, d, bp, bs);
    bl = 16 * cd(k);
    for (int i = 0; i < q.size(); i++) begin rx_drv[k] = q[i]; step(bl); end
    if (hold > 0) step(hold);
    rx_drv[k] = 1'b1;
    step(bl);
    expq[k].push_back({bp && pe(k) != 0, bs, d});
  endtask
  task automatic rx_check(input int k);
    chk($sformatf("rx_count[%0d]", k), rxq[k].size(), expq[k].size());
    for (int i = rd[k]; i < expq[k].size(); i++)
      chk($sformatf("rx_word%0d[%0d] {perr,ferr,data}", i, k), i < rxq[k].size() ? rxq[k][i] : 10'bx, expq[k][i]);
    rd[k] = expq[k].size();
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      tx_data[k] = '0; tx_valid[k] = 1'b0; lb[k] = 1'b1; rx_drv[k] = 1'b1; rd[k] = 0;
    end
    step(3);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_tx_out[%0d]", k), tx_out[k], 1);
      chk($sformatf("rst_tx_ready[%0d]", k), tx_ready[k], 1);
      chk($sformatf("rst_tx_busy[%0d]", k), tx_busy[k], 0);
      chk($sformatf("rst_rx[%0d] {valid,perr,ferr,data}", k), {rx_valid[k], rx_perr[k], rx_ferr[k], rx_data[k]}, 0);
    end
    rst_n = 1'b1;
    step(2);
    tx_frame(0, 8'hA5);
    tx_frame(1, 8'hA5);
    tx_frame(2, 8'hA5);
    for (int k = 0; k < N; k++) rx_check(k);
    tx_frame(0, 8'h00);
    tx_frame(0, 8'hFF);
    tx_frame(0, 8'h3C);
    rx_check(0);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 3; j++) tx_frame(k, 8'($urandom));
      rx_check(k);
    end
    lb[1] = 1'b0;
    lb[2] = 1'b0;
    for (int k = 1; k < N; k++) begin
      for (int j = 0; j < 4; j++) rx_frame(k, 8'($urandom), 1'($urandom), 1'b0, 0);
      rx_check(k);
    end
    lb[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      rx_drv[0] = 1'b0;
      step(j == 0 ? 20 : $urandom_range(3, 28));
      rx_drv[0] = 1'b1;
      step(700);
    end
    rx_check(0);
    rx_frame(0, 8'h55, 1'b0, 1'b1, 200);
    rx_check(0);
    chk("rx_frame_err_held", rx_ferr[0], 1);
    rx_frame(0, 8'h12, 1'b0, 1'b0, 0);
    rx_check(0);
    chk("rx_frame_err_clear", rx_ferr[0], 0);
    lb[0] = 1'b1;
    tx_data[0] = 8'h5A;
    tx_valid[0] = 1'b1;
    step(1);
    tx_valid[0] = 1'b0;
    step(4 * 64 + 30);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_out", tx_out[0], 1);
    chk("midrst_tx_ready", tx_ready[0], 1);
    chk("midrst_tx_busy", tx_busy[0], 0);
    chk("midrst_rx_data", rx_data[0], 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    tx_frame(0, 8'h81);
    step(64);
    rx_check(0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
